switch_sequencer: RTL and testbench

Multi-channel, clocked successor of the single timed switch model (init state plus one toggle time). Drives CHANNELS independent on/off switch controls. Each channel toggles at a per-channel programmed list of up to DEPTH tick times, starting from a programmable initial state. It sits between the testbench/stimulus configuration path and the switch-controlled devices (relay/switch subcircuits) in the mixed-mode netlist.

---
 rtl/switch_seq_pkg.sv | 25 ++
 rtl/switch_sequencer_if.sv | 47 ++++
 rtl/switch_seq_channel.sv | 82 ++++++++
 rtl/switch_sequencer.sv | 104 ++++++++++
 tb/tb_switch_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/switch_seq_pkg.sv
// Shared definitions for the switch sequencer: FSM state encoding,
// default geometry and the helpers that size channel/entry indices.
package switch_seq_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int DEPTH_DEF    = 8;
  localparam int TW_DEF       = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold a count from 0 up to and including d.
  function automatic int len_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/switch_sequencer_if.sv
// Configuration, control and switch-output bundle of switch_sequencer.
// The period signal exists only when SWITCH_SEQ_REPEAT_EN is defined.
interface switch_sequencer_if #(
  parameter int CHANNELS = switch_seq_pkg::CHANNELS_DEF,
  parameter int DEPTH    = switch_seq_pkg::DEPTH_DEF,
  parameter int TW       = switch_seq_pkg::TW_DEF
);
  localparam int CW = switch_seq_pkg::idx_w(CHANNELS);
  localparam int AW = switch_seq_pkg::idx_w(DEPTH);
  localparam int LW = switch_seq_pkg::len_w(DEPTH);

  logic                cfg_we;
  logic                cfg_hdr;
  logic [CW-1:0]       cfg_ch;
  logic [AW-1:0]       cfg_idx;
  logic [TW-1:0]       cfg_time;
  logic                cfg_init;
  logic [LW-1:0]       cfg_len;
  logic                start;
  logic                stop;
`ifdef SWITCH_SEQ_REPEAT_EN
  logic [TW-1:0]       period;
`endif
  logic [CHANNELS-1:0] sw_out;
  logic [CHANNELS-1:0] evt;
  logic                busy;
  logic                done;

  modport master (
`ifdef SWITCH_SEQ_REPEAT_EN
    output period,
`endif
    output cfg_we, cfg_hdr, cfg_ch, cfg_idx, cfg_time, cfg_init, cfg_len,
    output start, stop,
    input  sw_out, evt, busy, done
  );

  modport slave (
`ifdef SWITCH_SEQ_REPEAT_EN
    input  period,
`endif
    input  cfg_we, cfg_hdr, cfg_ch, cfg_idx, cfg_time, cfg_init, cfg_len,
    input  start, stop,
    output sw_out, evt, busy, done
  );

endinterface

// File: rtl/switch_seq_channel.sv
// One switch channel: toggle-time table, header (init bit, length),
// entry pointer and the compare/toggle step. finished_o reports whether
// the pointer reaches the length once this cycle's toggle is taken.
module switch_seq_channel
  import switch_seq_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter int  TW    = TW_DEF,
  localparam int AW    = idx_w(DEPTH),
  localparam int LW    = len_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_time_i,
  input  logic          wr_hdr_i,
  input  logic [AW-1:0] idx_i,
  input  logic [TW-1:0] time_i,
  input  logic          init_i,
  input  logic [LW-1:0] len_i,
  input  logic          reload_i,
  input  logic          run_i,
  input  logic [TW-1:0] tick_i,
  output logic          sw_o,
  output logic          evt_o,
  output logic          finished_o
);

  logic [TW-1:0] tbl_q [DEPTH];
  logic [LW-1:0] len_q;
  logic [LW-1:0] ptr_q;
  logic [LW-1:0] ptr_d;
  logic          init_q;
  logic          sw_q;
  logic          evt_q;
  logic          fire;

  // A pointer at len never indexes the table because ptr_q < len_q gates it.
  assign fire  = run_i && (ptr_q < len_q) && (tick_i >= tbl_q[ptr_q[AW-1:0]]);
  assign ptr_d = fire ? ptr_q + LW'(1) : ptr_q;

  assign finished_o = (ptr_d == len_q);
  assign sw_o       = sw_q;
  assign evt_o      = evt_q;

  // Toggle-time table writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (wr_time_i) begin
      tbl_q[idx_i] <= time_i;
    end
  end

  // Header writes; an oversized length is clamped to the table depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
      len_q  <= '0;
    end else if (wr_hdr_i) begin
      init_q <= init_i;
      len_q  <= (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
    end
  end

  // Sequence step: reload restores the initial state, otherwise at most one toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      sw_q  <= 1'b0;
      evt_q <= 1'b0;
    end else if (reload_i) begin
      ptr_q <= '0;
      sw_q  <= init_q;
      evt_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      evt_q <= fire;
      if (fire) sw_q <= ~sw_q;
    end
  end

endmodule

// File: rtl/switch_sequencer.sv
// Multi-channel timed switch sequencer: IDLE/RUN/DONE control, shared
// tick counter and configuration decode over per-channel toggle tables.
// Define SWITCH_SEQ_REPEAT_EN to add a periodic restart via bus.period.
module switch_sequencer
  import switch_seq_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TW       = TW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  switch_sequencer_if.slave  bus
);
  localparam int CW = idx_w(CHANNELS);

  state_e              state_q;
  logic [TW-1:0]       tick_q;
  logic [CHANNELS-1:0] sw_vec;
  logic [CHANNELS-1:0] evt_vec;
  logic [CHANNELS-1:0] fin_vec;
  logic                cfg_ok;
  logic                stop_any;
  logic                start_go;
  logic                wrap;
  logic                rpt_on;
  logic                run_en;
  logic                reload;

  assign cfg_ok   = (state_q != ST_RUN);
  assign stop_any = bus.stop && (state_q != ST_IDLE);
  assign start_go = bus.start && !bus.stop && (state_q != ST_RUN);

`ifdef SWITCH_SEQ_REPEAT_EN
  logic [TW-1:0] period_q;

  assign rpt_on = (period_q != '0);
  assign wrap   = (state_q == ST_RUN) && rpt_on && (tick_q == period_q - TW'(1));

  // Period is captured when a sequence starts and held for the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           period_q <= '0;
    else if (start_go) period_q <= bus.period;
  end
`else
  assign rpt_on = 1'b0;
  assign wrap   = 1'b0;
`endif

  // Wrap suppresses this cycle's toggles and restarts every channel.
  assign run_en = (state_q == ST_RUN) && !stop_any && !wrap;
  assign reload = stop_any || start_go || wrap;

  assign bus.sw_out = sw_vec;
  assign bus.evt    = evt_vec;
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);

  // Control FSM and tick counter; stop wins over start and any toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
    end else if (stop_any) begin
      state_q <= ST_IDLE;
    end else if (start_go) begin
      state_q <= ST_RUN;
      tick_q  <= '0;
    end else if (state_q == ST_RUN) begin
      if (wrap) begin
        tick_q <= '0;
      end else begin
        if (tick_q != '1) tick_q <= tick_q + TW'(1);
        if ((tick_q == '1) || ((&fin_vec) && !rpt_on)) state_q <= ST_DONE;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic hit;
    assign hit = bus.cfg_we && cfg_ok && (bus.cfg_ch == CW'(c));

    switch_seq_channel #(
      .DEPTH (DEPTH),
      .TW    (TW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_time_i  (hit && !bus.cfg_hdr),
      .wr_hdr_i   (hit && bus.cfg_hdr),
      .idx_i      (bus.cfg_idx),
      .time_i     (bus.cfg_time),
      .init_i     (bus.cfg_init),
      .len_i      (bus.cfg_len),
      .reload_i   (reload),
      .run_i      (run_en),
      .tick_i     (tick_q),
      .sw_o       (sw_vec[c]),
      .evt_o      (evt_vec[c]),
      .finished_o (fin_vec[c])
    );
  end

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer (CHANNELS=4, DEPTH=8, TW=32).
module tb_switch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  switch_sequencer_if #(.CHANNELS(4), .DEPTH(8), .TW(32)) bus ();

  switch_sequencer #(.CHANNELS(4), .DEPTH(8), .TW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wr_hdr(input logic [1:0] ch, input logic init, input logic [3:0] len);
    bus.cfg_we = 1'b1; bus.cfg_hdr = 1'b1; bus.cfg_ch = ch;
    bus.cfg_init = init; bus.cfg_len = len;
    step();
    bus.cfg_we = 1'b0; bus.cfg_hdr = 1'b0;
  endtask

  task automatic wr_time(input logic [1:0] ch, input logic [2:0] idx, input logic [31:0] t);
    bus.cfg_we = 1'b1; bus.cfg_hdr = 1'b0; bus.cfg_ch = ch;
    bus.cfg_idx = idx; bus.cfg_time = t;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_hdr = 1'b0; bus.cfg_ch = '0; bus.cfg_idx = '0;
    bus.cfg_time = '0; bus.cfg_init = 1'b0; bus.cfg_len = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
`ifdef SWITCH_SEQ_REPEAT_EN
    bus.period = '0;
`endif

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    chk4("rst_sw", bus.sw_out, 4'b0000);
    chk4("rst_evt", bus.evt, 4'b0000);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);

    // All lengths zero: DONE one edge after start
    do_start();
    chk1("empty_busy_E0", bus.busy, 1'b1);
    step();
    chk1("empty_done_E1", bus.done, 1'b1);
    chk1("empty_busy_E1", bus.busy, 1'b0);
    chk4("empty_sw_E1", bus.sw_out, 4'b0000);

    // ch0 init=0, times {3,7,10}
    wr_hdr(2'd0, 1'b0, 4'd3);
    wr_time(2'd0, 3'd0, 32'd3);
    wr_time(2'd0, 3'd1, 32'd7);
    wr_time(2'd0, 3'd2, 32'd10);
    do_start();
    chk4("ch0_sw_E0", bus.sw_out, 4'b0000);
    chk1("ch0_done_E0", bus.done, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk1($sformatf("ch0_sw_E%0d", k), bus.sw_out[0], (k >= 4 && k < 8) || k >= 11);
      chk1($sformatf("ch0_evt_E%0d", k), bus.evt[0], k == 4 || k == 8 || k == 11);
      chk1($sformatf("ch0_done_E%0d", k), bus.done, k >= 11);
      chk1($sformatf("ch0_busy_E%0d", k), bus.busy, k < 11);
    end

    // ch1 init=1, times {5,2,5}: consecutive toggles at E6,E7,E8
    wr_hdr(2'd1, 1'b1, 4'd3);
    wr_time(2'd1, 3'd0, 32'd5);
    wr_time(2'd1, 3'd1, 32'd2);
    wr_time(2'd1, 3'd2, 32'd5);
    do_start();
    chk4("ch1_sw_E0", bus.sw_out, 4'b0010);
    chk1("ch1_done_E0", bus.done, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk1($sformatf("ch1_sw_E%0d", k), bus.sw_out[1], k < 6 || k == 7);
      chk1($sformatf("ch1_evt_E%0d", k), bus.evt[1], k >= 6 && k <= 8);
      chk1($sformatf("ch1_done_E%0d", k), bus.done, k >= 11);
    end

    // Config write in RUN ignored; stop at tick 4 restores init
    do_start();
    bus.cfg_we = 1'b1; bus.cfg_hdr = 1'b0; bus.cfg_ch = 2'd0;
    bus.cfg_idx = 3'd0; bus.cfg_time = 32'd1;
    step();
    bus.cfg_we = 1'b0;
    step();
    chk1("runwr_sw0_E2", bus.sw_out[0], 1'b0);
    step();
    chk1("runwr_sw0_E3", bus.sw_out[0], 1'b0);
    step();
    chk1("stop_sw0_E4", bus.sw_out[0], 1'b1);
    chk1("stop_evt0_E4", bus.evt[0], 1'b1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk4("stop_sw_E5", bus.sw_out, 4'b0010);
    chk4("stop_evt_E5", bus.evt, 4'b0000);
    chk1("stop_busy_E5", bus.busy, 1'b0);
    chk1("stop_done_E5", bus.done, 1'b0);

    // start and stop together in IDLE: nothing changes
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk1("ss_busy", bus.busy, 1'b0);
    chk1("ss_done", bus.done, 1'b0);
    chk4("ss_sw", bus.sw_out, 4'b0010);
    step();
    chk1("ss_busy2", bus.busy, 1'b0);

    // Asynchronous reset at tick 6
    do_start();
    for (int k = 1; k <= 6; k++) step();
    chk4("pre_rst_sw_E6", bus.sw_out, 4'b0001);
    chk1("pre_rst_busy_E6", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk4("async_rst_sw", bus.sw_out, 4'b0000);
    chk4("async_rst_evt", bus.evt, 4'b0000);
    chk1("async_rst_busy", bus.busy, 1'b0);
    step();
    rst = 1'b0;
    step();
    do_start();
    step();
    chk1("post_rst_done_E1", bus.done, 1'b1);
    chk4("post_rst_sw_E1", bus.sw_out, 4'b0000);

    // Length 15 clamps to 8; cleared table times all fire from E1
    wr_hdr(2'd2, 1'b0, 4'd15);
    do_start();
    step();
    chk4("clamp_sw_E1", bus.sw_out, 4'b0100);
    for (int k = 2; k <= 8; k++) begin
      step();
      chk1($sformatf("clamp_done_E%0d", k), bus.done, k == 8);
    end
    chk4("clamp_sw_E8", bus.sw_out, 4'b0000);

`ifdef SWITCH_SEQ_REPEAT_EN
    // Period 12, ch0 {3,7}: toggles at E4, E8, E16, E20; never done
    wr_hdr(2'd2, 1'b0, 4'd0);
    wr_hdr(2'd0, 1'b0, 4'd2);
    wr_time(2'd0, 3'd0, 32'd3);
    wr_time(2'd0, 3'd1, 32'd7);
    bus.period = 32'd12;
    do_start();
    for (int k = 1; k <= 24; k++) begin
      step();
      chk1($sformatf("rpt_sw_E%0d", k), bus.sw_out[0], (k >= 4 && k < 8) || (k >= 16 && k < 20));
      chk1($sformatf("rpt_evt_E%0d", k), bus.evt[0], k == 4 || k == 8 || k == 16 || k == 20);
      chk1($sformatf("rpt_done_E%0d", k), bus.done, 1'b0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.period = 32'd0;
    do_start();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk1($sformatf("p0_done_E%0d", k), bus.done, k == 8);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
